// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-stage bus (imem request/response, redirect from execute, decode-side queue head); master = fetch stage
interface if_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  modport master (
    output imem_req_valid, imem_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: PC + one-outstanding imem fetch + 2-entry {pc,instr} queue to decode; ports clk, rst (sync, high), f (if_fetch_if.master)
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master f
);
  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;
  state_t      st;
  logic [31:0] pc, req_pc;
  logic [31:0] q_pc [2];
  logic [31:0] q_instr [2];
  logic        hd, tl;
  logic [1:0]  cnt;
  logic        req, push, pop;
  always_comb begin
    req  = !rst && st == FETCH && cnt != 2'd2 && !f.redirect_valid;
    push = st == WAIT && f.imem_resp_valid && !f.redirect_valid;
    pop  = cnt != 2'd0 && f.out_ready && !f.redirect_valid;
  end
  assign f.imem_req_valid = req;
  assign f.imem_addr      = pc;
  assign f.out_valid      = cnt != 2'd0;
  assign f.out_pc         = q_pc[hd];
  assign f.out_instr      = q_instr[hd];
  always_ff @(posedge clk) begin
    if (rst || f.redirect_valid) begin
      cnt <= 2'd0;
      hd  <= 1'b0;
      tl  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= 32'h0;
        q_instr[i] <= NOP_INSTR;
      end
    end else begin
      if (push) begin
        q_pc[tl]    <= req_pc;
        q_instr[tl] <= f.imem_resp_data;
        tl          <= ~tl;
      end
      if (pop) hd <= ~hd;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= 32'h0;
      st     <= FETCH;
    end else if (f.redirect_valid) begin
      pc <= f.redirect_pc & 32'hFFFF_FFFC;
      // a redirect while a response is still owed must swallow that stale response first
      st <= (st != FETCH && !f.imem_resp_valid) ? DROP : FETCH;
    end else if (req && f.imem_req_ready) begin
      req_pc <= pc;
      pc     <= pc + 32'd4;
      st     <= WAIT;
    end else if (st != FETCH && f.imem_resp_valid) begin
      st <= FETCH;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized scoreboard bench for if_fetch with a behavioural fetch-stream model
module tb_if_fetch;
  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  if_fetch_if bus();
  if_fetch #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .f(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1, p_ready = 100, p_oready = 100, p_redir = 0;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] pc; bit stale;} pend_t;
  mreq_t       mem[$];
  pend_t       pend[$];
  pend_t       pp;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] plog[$];
  logic [31:0] mpc = RPC;
  bit          found;
  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_log(string name, int k, logic [31:0] val);
    if (plog.size() > k) chk(name, plog[k], val);
    else chk({name, "_count"}, 32'(plog.size()), 32'(k + 1));
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step();
    @(posedge clk);
    #1;
    bus.imem_req_ready  = $urandom_range(99, 0) < p_ready;
    bus.out_ready       = $urandom_range(99, 0) < p_oready;
    bus.redirect_valid  = $urandom_range(99, 0) < p_redir;
    bus.redirect_pc     = $urandom;
    bus.imem_resp_valid = !rst && mem.size() > 0 && mem[0].due <= cyc;
    bus.imem_resp_data  = bus.imem_resp_valid ? memf(mem[0].addr) : $urandom;
  endtask
  // memory: in-order responses, each at least one cycle after acceptance
  always @(negedge clk) begin
    if (rst) mem.delete();
    else begin
      if (bus.imem_resp_valid && mem.size() > 0) void'(mem.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready)
        mem.push_back('{bus.imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    end
  end
  // reference model: expected fetch address stream and the instructions decode should see
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      exp_q.delete();
      mpc = RPC;
    end else begin
      chk("req_valid", 32'(bus.imem_req_valid), 32'(pend.size() == 0 && exp_q.size() < 2 && !bus.redirect_valid));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (bus.imem_resp_valid && pend.size() > 0) begin
        pp = pend.pop_front();
        if (!pp.stale && !bus.redirect_valid) exp_q.push_back({pp.pc, memf(pp.pc)});
      end
      if (bus.redirect_valid) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_q.delete();
        mpc = bus.redirect_pc & ~32'h3;
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("imem_addr", bus.imem_addr, mpc);
        pend.push_back('{mpc, 1'b0});
        mpc += 32'd4;
      end
    end
  end
  // monitor: every accepted head is compared with the oldest expected entry
  always @(negedge clk) begin
    #1;
    if (!rst && !bus.redirect_valid && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("pop_depth", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("out_pc", bus.out_pc, e[63:32]);
        chk("out_instr", bus.out_instr, e[31:0]);
      end
      plog.push_back(bus.out_pc);
    end
  end
  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.out_ready       = 1'b0;
    step();
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, NOP);
    chk("rst_imem_addr", bus.imem_addr, RPC);
    step();
    rst = 1'b0;
    plog.delete();
    repeat (14) step();
    chk_log("seq0", 0, 32'h1000);
    chk_log("seq1", 1, 32'h1004);
    chk_log("seq2", 2, 32'h1008);
    p_oready = 0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (12) step();
    @(negedge clk);
    chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("full_imem_addr", bus.imem_addr, 32'h1008);
    chk("full_out_pc", bus.out_pc, 32'h1000);
    p_oready = 100;
    plog.delete();
    repeat (12) step();
    chk_log("drain0", 0, 32'h1000);
    chk_log("drain1", 1, 32'h1004);
    chk_log("drain2", 2, 32'h1008);
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      step();
      if (pend.size() == 1 && !bus.imem_resp_valid) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2003;
        found = 1'b1;
      end
    end
    chk("wait_redirect_found", 32'(found), 32'd1);
    plog.delete();
    step();
    @(negedge clk);
    chk("redir_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (15) step();
    chk_log("redir_target", 0, 32'h2000);
    lat_min = 1;
    lat_max = 1;
    p_oready = 50;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      step();
      if (bus.imem_resp_valid && exp_q.size() == 1) begin
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_3000;
        found = 1'b1;
      end
    end
    chk("resp_pop_redirect_found", 32'(found), 32'd1);
    step();
    @(negedge clk);
    chk("collide_out_valid", 32'(bus.out_valid), 32'd0);
    chk("collide_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("collide_imem_addr", bus.imem_addr, 32'h0000_3000);
    p_oready = 100;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      step();
      if (pend.size() == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        found = 1'b1;
      end
    end
    chk("wrap_redirect_found", 32'(found), 32'd1);
    plog.delete();
    repeat (12) step();
    chk_log("wrap0", 0, 32'hFFFF_FFFC);
    chk_log("wrap1", 1, 32'h0000_0000);
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      step();
      if (pend.size() == 1) begin
        rst = 1'b1;
        found = 1'b1;
      end
    end
    chk("mid_reset_found", 32'(found), 32'd1);
    step();
    @(negedge clk);
    chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_pc", bus.out_pc, 32'h0);
    chk("mid_rst_out_instr", bus.out_instr, NOP);
    chk("mid_rst_imem_addr", bus.imem_addr, RPC);
    step();
    rst = 1'b0;
    plog.delete();
    repeat (12) step();
    chk_log("post_reset_first", 0, RPC);
    lat_min = 1;
    lat_max = 4;
    p_ready = 70;
    p_oready = 60;
    p_redir = 5;
    repeat (3000) step();
    p_redir = 0;
    repeat (10) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RISC-V core. Holds the program counter, issues word fetches to instruction memory over a valid/ready request with a fixed-order response, and buffers returned instructions in a 2-entry queue. The queue presents `{pc, instruction}` to decode, where the instruction word drives the immediate generator and the register decode. Redirects from execute (taken branch, jal, jalr) flush the queue and discard in-flight responses.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h0000_0013` (addi x0,x0,0): queue storage reset/flush value.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `imem_req_valid`  out  1: fetch request.
- `imem_req_ready`  in  1: memory accepts the request this cycle.
- `imem_addr`  out  32: word address of the request, always equal to `pc`.
- `imem_resp_valid`  in  1: response data valid. At most one response per accepted request, in order, no earlier than the cycle after acceptance.
- `imem_resp_data`  in  32: fetched instruction word.
- `redirect_valid`  in  1: control-flow redirect from execute.
- `redirect_pc`  in  32: redirect target. Bits [1:0] are ignored and treated as 0.
- `out_valid`  out  1: queue head valid.
- `out_ready`  in  1: decode accepts the head.
- `out_pc`  out  32: PC of the head entry.
- `out_instr`  out  32: instruction of the head entry.

## Operation
- State: `pc`, `req_pc`, FSM {FETCH, WAIT, DROP}, 2-entry queue (head pointer, tail pointer, count 0..2).
- `imem_req_valid` = (state==FETCH) && (count<2) && !redirect_valid.
  - It has no combinational dependence on `out_ready` or `imem_resp_valid`.
- Request handshake (`imem_req_valid && imem_req_ready`): `req_pc <= pc`, `pc <= pc + 4` (mod 2^32, wraps from `32'hFFFF_FFFC` to 0), FETCH→WAIT.
- WAIT with `imem_resp_valid` and no redirect: push `{req_pc, imem_resp_data}` to the tail, WAIT→FETCH.
  - Space is guaranteed because a request is issued only when count<2.
- Pop: `out_valid && out_ready` advances the head.
  - Push and pop in the same cycle leave count unchanged.
- `out_valid` = (count!=0). `out_pc` and `out_instr` always show the head entry storage, valid or not.
- Redirect (`redirect_valid=1`) has priority over every other event in that cycle:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - Queue flushed: count=0, pointers=0, entries reset to `{0, NOP_INSTR}`. Any same-cycle pop or push is discarded.
  - FETCH→FETCH (no request issued this cycle).
  - WAIT with `imem_resp_valid` in the same cycle: response dropped, →FETCH.
  - WAIT without response: →DROP.
  - DROP: stays DROP, `pc` updated.
- DROP: `imem_resp_valid` → discard data, →FETCH. No requests are issued in DROP.
- Reset:
  - `pc=RESET_PC`, `req_pc=0`, state FETCH, count 0, pointers 0.
  - All entries `{32'h0, NOP_INSTR}`.
  - Hence `imem_req_valid=0` during reset, `out_valid=0`, `out_pc=0`, `out_instr=NOP_INSTR`, `imem_addr=RESET_PC`.
  - Reset mid-request abandons the outstanding response. The memory is reset by the same `rst`.

## Timing
- Request-to-queue: a response in cycle N makes `out_valid=1` in cycle N+1.
- With a 1-cycle memory (accept N, respond N+1), steady-state throughput is 1 instruction per 2 cycles.
- Redirect in cycle N:
  - `out_valid=0` in N+1.
  - First request to the target issued in N+1 if the state was FETCH, or if the state was WAIT and the response arrived in N.
  - Otherwise issued the cycle after the stale response.
- `out_*` are driven from registers only; decode sees no combinational path from memory.
- Queue full (count=2): requests stop. They resume the cycle after a pop makes count<2.

## Test plan
- Reset with `RESET_PC=32'h0000_1000`, memory ready and 1-cycle latency, `out_ready=1`:
  - Requests to 0x1000, 0x1004, 0x1008 on alternate cycles.
  - `out_pc` follows the same sequence, with `out_instr` equal to the returned words.
- `out_ready=0` throughout:
  - Exactly 2 responses are queued, then `imem_req_valid` stays 0 with `imem_addr=0x1008`.
  - Raising `out_ready` pops 0x1000, then 0x1004, and fetching resumes at 0x1008.
- Redirect to 0x2003 while in WAIT (memory latency 3):
  - Stale response is discarded and the queue is empty the next cycle.
  - Next request goes to 0x2000, and the next `out_pc` is 0x2000.
- Redirect in the same cycle as a response and a pop with count=1:
  - count=0 next cycle, response dropped, next request to the target the following cycle.
- PC wrap: redirect to 0xFFFF_FFFC.
  - Fetches 0xFFFF_FFFC then 0x0000_0000, and `out_pc` values match.
- Assert `rst` while a request is outstanding:
  - All outputs return to their reset values the next cycle.
  - The first post-reset request goes to `RESET_PC`.
